mips_cpu_muldiv: RTL



---
 rtl/mips_cpu_muldiv.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        counter;
    logic [2*WIDTH-1:0]   prod;      // product accumulator; low half doubles as quotient/dividend
    logic [WIDTH-1:0]     mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     a_orig;
    logic                 is_div, res_neg, rem_neg, div_zero;

    logic                 signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_abs     = a_neg ? (WIDTH'(0) - a) : a;
    assign b_abs     = b_neg ? (WIDTH'(0) - b) : b;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign div_shift = {rem, prod[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand};

    assign prod_fix  = res_neg ? ((2*WIDTH)'(0) - prod) : prod;
    assign q_fix     = res_neg ? (WIDTH'(0) - prod[WIDTH-1:0]) : prod[WIDTH-1:0];
    assign r_fix     = rem_neg ? (WIDTH'(0) - rem) : rem;

    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MULT || op == OP_MULTU)
                        state_next = S_MUL;
                    else if (op == OP_DIV || op == OP_DIVU)
                        state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: if (counter == CW'(1)) state_next = S_FIX;
            S_FIX:        state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            prod     <= '0;
            mcand    <= '0;
            rem      <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else if (en) begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi   <= a;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= a;
                            done <= 1'b1;
                        end else if (op == OP_MULT || op == OP_MULTU) begin
                            prod    <= {{WIDTH{1'b0}}, b_abs};
                            mcand   <= a_abs;
                            is_div  <= 1'b0;
                            res_neg <= a_neg ^ b_neg;
                            counter <= CW'(WIDTH);
                        end else if (op == OP_DIV || op == OP_DIVU) begin
                            prod     <= {{WIDTH{1'b0}}, a_abs};
                            mcand    <= b_abs;
                            rem      <= '0;
                            a_orig   <= a;
                            is_div   <= 1'b1;
                            res_neg  <= a_neg ^ b_neg;
                            rem_neg  <= a_neg;
                            div_zero <= (b == '0);
                            counter  <= CW'(WIDTH);
                        end
                    end
                end
                S_MUL: begin
                    prod    <= {mul_sum, prod[WIDTH-1:1]};
                    counter <= counter - CW'(1);
                end
                S_DIV: begin
                    // Restoring step: keep the shifted remainder when the trial subtraction borrows
                    if (!div_trial[WIDTH]) begin
                        rem               <= div_trial[WIDTH-1:0];
                        prod[WIDTH-1:0]   <= {prod[WIDTH-2:0], 1'b1};
                    end else begin
                        rem               <= div_shift[WIDTH-1:0];
                        prod[WIDTH-1:0]   <= {prod[WIDTH-2:0], 1'b0};
                    end
                    counter <= counter - CW'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= a_orig;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
